// File: rtl/rggen_apb_requester_pkg.sv
// Shared types and constants for the APB requester bridge.
package rggen_apb_requester_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess,
    StResponse
  } state_e;

  localparam logic [1:0] STATUS_OKAY        = 2'b00;
  localparam logic [1:0] STATUS_SLAVE_ERROR = 2'b10;
  localparam logic [1:0] STATUS_TIMEOUT     = 2'b11;

endpackage

// File: rtl/rggen_apb_requester_if.sv
// Command/response channels plus APB4 request/completion signals of the requester.
interface rggen_apb_requester_if #(
  parameter int unsigned ADDRESS_WIDTH = 16,
  parameter int unsigned DATA_WIDTH    = 32
);
  logic                      i_command_valid;
  logic                      o_command_ready;
  logic                      i_write;
  logic [ADDRESS_WIDTH-1:0]  i_address;
  logic [2:0]                i_prot;
  logic [DATA_WIDTH/8-1:0]   i_strobe;
  logic [DATA_WIDTH-1:0]     i_write_data;
  logic                      o_response_valid;
  logic                      i_response_ready;
  logic [DATA_WIDTH-1:0]     o_read_data;
  logic [1:0]                o_status;
  logic [ADDRESS_WIDTH-1:0]  o_paddr;
  logic [2:0]                o_pprot;
  logic                      o_psel;
  logic                      o_penable;
  logic                      o_pwrite;
  logic [DATA_WIDTH-1:0]     o_pwdata;
  logic [DATA_WIDTH/8-1:0]   o_pstrb;
  logic                      i_pready;
  logic [DATA_WIDTH-1:0]     i_prdata;
  logic                      i_pslverr;

  // Requester side.
  modport master (
    input  i_command_valid, i_write, i_address, i_prot, i_strobe, i_write_data,
    input  i_response_ready, i_pready, i_prdata, i_pslverr,
    output o_command_ready, o_response_valid, o_read_data, o_status,
    output o_paddr, o_pprot, o_psel, o_penable, o_pwrite, o_pwdata, o_pstrb
  );

  // Environment side: command source, response sink and APB completer.
  modport slave (
    output i_command_valid, i_write, i_address, i_prot, i_strobe, i_write_data,
    output i_response_ready, i_pready, i_prdata, i_pslverr,
    input  o_command_ready, o_response_valid, o_read_data, o_status,
    input  o_paddr, o_pprot, o_psel, o_penable, o_pwrite, o_pwdata, o_pstrb
  );

endinterface

// File: rtl/rggen_apb_timeout_counter.sv
// Counts stalled ACCESS cycles; expired flags the last permitted cycle.
module rggen_apb_timeout_counter #(
  parameter int unsigned LIMIT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CountWidth = (LIMIT == 0) ? 1 : $clog2(LIMIT + 1);

  if (LIMIT == 0) begin : g_disabled
    logic unused_inputs;
    assign unused_inputs = ^{clk, rst, clear, enable};
    assign expired       = 1'b0;
  end else begin : g_enabled
    logic [CountWidth-1:0] count_q, count_d;

    always_comb begin
      count_d = count_q;
      if (clear) begin
        count_d = '0;
      end else if (enable && !expired) begin
        count_d = count_q + CountWidth'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        count_q <= '0;
      end else begin
        count_q <= count_d;
      end
    end

    assign expired = (count_q == CountWidth'(LIMIT - 1));
  end

endmodule

// File: rtl/rggen_apb_requester.sv
// APB4 initiator: one command -> one SETUP/ACCESS transfer -> one response.
module rggen_apb_requester
  import rggen_apb_requester_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input logic                   clk,
  input logic                   rst,
  rggen_apb_requester_if.master bus
);

  localparam int unsigned StrbWidth = DATA_WIDTH / 8;

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] paddr_q, paddr_d;
  logic [2:0]               pprot_q, pprot_d;
  logic                     pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0]    pwdata_q, pwdata_d;
  logic [StrbWidth-1:0]     pstrb_q, pstrb_d;
  logic                     psel_q, psel_d;
  logic                     penable_q, penable_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
  logic [1:0]               status_q, status_d;
  logic                     timeout_expired;

  rggen_apb_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_counter (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_q == StSetup),
    .enable  ((state_q == StAccess) && !bus.i_pready),
    .expired (timeout_expired)
  );

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pprot_d  = pprot_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    pstrb_d  = pstrb_q;
    rdata_d  = rdata_q;
    status_d = status_q;

    case (state_q)
      StIdle: begin
        if (bus.i_command_valid) begin
          state_d  = StSetup;
          paddr_d  = bus.i_address;
          pprot_d  = bus.i_prot;
          pwrite_d = bus.i_write;
          pwdata_d = bus.i_write ? bus.i_write_data : '0;
          pstrb_d  = bus.i_write ? bus.i_strobe : '0;
        end
      end
      StSetup: state_d = StAccess;
      StAccess: begin
        // A completion in the limit cycle takes priority over the abort.
        if (bus.i_pready) begin
          state_d  = StResponse;
          rdata_d  = (!pwrite_q && !bus.i_pslverr) ? bus.i_prdata : '0;
          status_d = bus.i_pslverr ? STATUS_SLAVE_ERROR : STATUS_OKAY;
        end else if (timeout_expired) begin
          state_d  = StResponse;
          rdata_d  = '0;
          status_d = STATUS_TIMEOUT;
        end
      end
      StResponse: begin
        if (bus.i_response_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Strobes are derived from the next state so they come straight off flops.
    psel_d      = (state_d == StSetup) || (state_d == StAccess);
    penable_d   = (state_d == StAccess);
    rsp_valid_d = (state_d == StResponse);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      paddr_q     <= '0;
      pprot_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      status_q    <= STATUS_OKAY;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pprot_q     <= pprot_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      status_q    <= status_d;
    end
  end

  assign bus.o_command_ready  = (state_q == StIdle);
  assign bus.o_response_valid = rsp_valid_q;
  assign bus.o_read_data      = rdata_q;
  assign bus.o_status         = status_q;
  assign bus.o_paddr          = paddr_q;
  assign bus.o_pprot          = pprot_q;
  assign bus.o_psel           = psel_q;
  assign bus.o_penable        = penable_q;
  assign bus.o_pwrite         = pwrite_q;
  assign bus.o_pwdata         = pwdata_q;
  assign bus.o_pstrb          = pstrb_q;

endmodule

// File: tb/tb_rggen_apb_requester.sv
// Directed bench for rggen_apb_requester with a timeout limit of 8 ACCESS cycles.
module tb_rggen_apb_requester;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  rggen_apb_requester_if #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW)
  ) bus ();

  rggen_apb_requester #(
    .ADDRESS_WIDTH  (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_cmd(input logic w, input logic [15:0] a, input logic [2:0] p,
                           input logic [3:0] s, input logic [31:0] d);
    bus.i_command_valid = 1'b1;
    bus.i_write         = w;
    bus.i_address       = a;
    bus.i_prot          = p;
    bus.i_strobe        = s;
    bus.i_write_data    = d;
  endtask

  // Issue one command and act as completer; waits < 0 means pready never comes.
  task automatic run_xfer(input string tag, input logic w, input logic [15:0] a,
                          input logic [2:0] p, input logic [3:0] s, input logic [31:0] d,
                          input int waits, input logic [31:0] rdat, input logic err,
                          output int acc);
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
    exp_strb  = w ? s : 4'h0;
    exp_wdata = w ? d : 32'h0;
    @(negedge clk);
    drive_cmd(w, a, p, s, d);
    check_eq({tag, " cmd_ready"}, 64'(bus.o_command_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    bus.i_command_valid = 1'b0;
    check_eq({tag, " setup psel"}, 64'(bus.o_psel), 64'd1);
    check_eq({tag, " setup penable"}, 64'(bus.o_penable), 64'd0);
    check_eq({tag, " paddr"}, 64'(bus.o_paddr), 64'(a));
    check_eq({tag, " pwrite"}, 64'(bus.o_pwrite), 64'(w));
    check_eq({tag, " pprot"}, 64'(bus.o_pprot), 64'(p));
    check_eq({tag, " pstrb"}, 64'(bus.o_pstrb), 64'(exp_strb));
    check_eq({tag, " pwdata"}, 64'(bus.o_pwdata), 64'(exp_wdata));
    acc = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (!bus.o_penable) break;
      acc++;
      check_eq({tag, " access psel"}, 64'(bus.o_psel), 64'd1);
      check_eq({tag, " access paddr"}, 64'(bus.o_paddr), 64'(a));
      check_eq({tag, " access pstrb"}, 64'(bus.o_pstrb), 64'(exp_strb));
      if (waits >= 0 && acc == waits + 1) begin
        bus.i_pready  = 1'b1;
        bus.i_prdata  = rdat;
        bus.i_pslverr = err;
      end else begin
        bus.i_pready  = 1'b0;
        bus.i_prdata  = 32'hBAD0_BAD0;
        bus.i_pslverr = 1'b1;
      end
    end
    bus.i_pready  = 1'b0;
    bus.i_pslverr = 1'b0;
    check_eq({tag, " done psel"}, 64'(bus.o_psel), 64'd0);
    check_eq({tag, " rsp_valid"}, 64'(bus.o_response_valid), 64'd1);
  endtask

  // Stall the response for a number of cycles, optionally offering a new command.
  task automatic finish_rsp(input string tag, input logic [31:0] exp_rdata,
                            input logic [1:0] exp_status, input int stall, input logic try_cmd);
    for (int i = 0; i < stall; i++) begin
      if (try_cmd) drive_cmd(1'b1, 16'h0300, 3'b001, 4'hF, 32'h1111_2222);
      check_eq({tag, " stall valid"}, 64'(bus.o_response_valid), 64'd1);
      check_eq({tag, " stall rdata"}, 64'(bus.o_read_data), 64'(exp_rdata));
      check_eq({tag, " stall status"}, 64'(bus.o_status), 64'(exp_status));
      check_eq({tag, " stall cmd_ready"}, 64'(bus.o_command_ready), 64'd0);
      check_eq({tag, " stall psel"}, 64'(bus.o_psel), 64'd0);
      @(negedge clk);
    end
    bus.i_command_valid  = 1'b0;
    check_eq({tag, " rdata"}, 64'(bus.o_read_data), 64'(exp_rdata));
    check_eq({tag, " status"}, 64'(bus.o_status), 64'(exp_status));
    bus.i_response_ready = 1'b1;
    @(negedge clk);
    bus.i_response_ready = 1'b0;
    check_eq({tag, " rsp cleared"}, 64'(bus.o_response_valid), 64'd0);
    check_eq({tag, " idle cmd_ready"}, 64'(bus.o_command_ready), 64'd1);
    check_eq({tag, " idle psel"}, 64'(bus.o_psel), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    rst                  = 1'b1;
    bus.i_command_valid  = 1'b0;
    bus.i_write          = 1'b0;
    bus.i_address        = '0;
    bus.i_prot           = '0;
    bus.i_strobe         = '0;
    bus.i_write_data     = '0;
    bus.i_response_ready = 1'b0;
    bus.i_pready         = 1'b0;
    bus.i_prdata         = '0;
    bus.i_pslverr        = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset cmd_ready", 64'(bus.o_command_ready), 64'd1);
    check_eq("reset psel", 64'(bus.o_psel), 64'd0);
    check_eq("reset penable", 64'(bus.o_penable), 64'd0);
    check_eq("reset rsp_valid", 64'(bus.o_response_valid), 64'd0);
    check_eq("reset paddr", 64'(bus.o_paddr), 64'd0);
    check_eq("reset rdata", 64'(bus.o_read_data), 64'd0);
    check_eq("reset status", 64'(bus.o_status), 64'd0);
    rst = 1'b0;

    run_xfer("wr0", 1'b1, 16'h0010, 3'b000, 4'hF, 32'hDEAD_BEEF, 0, 32'h0, 1'b0, acc);
    check_eq("wr0 access cycles", 64'(acc), 64'd1);
    finish_rsp("wr0", 32'h0, 2'b00, 0, 1'b0);

    run_xfer("rd3", 1'b0, 16'h0024, 3'b010, 4'hF, 32'hCAFE_F00D, 3, 32'h1234_5678, 1'b0,
             acc);
    check_eq("rd3 access cycles", 64'(acc), 64'd4);
    finish_rsp("rd3", 32'h1234_5678, 2'b00, 0, 1'b0);

    run_xfer("rderr", 1'b0, 16'h0100, 3'b000, 4'h0, 32'h0, 0, 32'h5555_AAAA, 1'b1, acc);
    check_eq("rderr access cycles", 64'(acc), 64'd1);
    finish_rsp("rderr", 32'h0, 2'b10, 0, 1'b0);

    run_xfer("wr2", 1'b1, 16'h0200, 3'b100, 4'b0101, 32'h0BAD_F00D, 2, 32'hFFFF_FFFF, 1'b0,
             acc);
    check_eq("wr2 access cycles", 64'(acc), 64'd3);
    finish_rsp("wr2", 32'h0, 2'b00, 0, 1'b0);

    run_xfer("tmo", 1'b0, 16'h0040, 3'b000, 4'h0, 32'h0, -1, 32'h0, 1'b0, acc);
    check_eq("tmo access cycles", 64'(acc), 64'd8);
    finish_rsp("tmo", 32'h0, 2'b11, 0, 1'b0);

    run_xfer("tmo_edge", 1'b0, 16'h0044, 3'b000, 4'h0, 32'h0, 7, 32'hA5A5_A5A5, 1'b0, acc);
    check_eq("tmo_edge access cycles", 64'(acc), 64'd8);
    finish_rsp("tmo_edge", 32'hA5A5_A5A5, 2'b00, 0, 1'b0);

    run_xfer("bp", 1'b0, 16'h0050, 3'b000, 4'h0, 32'h0, 1, 32'h0F0F_1234, 1'b0, acc);
    check_eq("bp access cycles", 64'(acc), 64'd2);
    finish_rsp("bp", 32'h0F0F_1234, 2'b00, 5, 1'b1);
    run_xfer("bp2", 1'b1, 16'h0300, 3'b001, 4'hF, 32'h1111_2222, 0, 32'h0, 1'b0, acc);
    check_eq("bp2 access cycles", 64'(acc), 64'd1);
    finish_rsp("bp2", 32'h0, 2'b00, 0, 1'b0);

    // Reset while the completer is stalling in ACCESS.
    @(negedge clk);
    drive_cmd(1'b0, 16'h0060, 3'b000, 4'h0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    bus.i_command_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("rst pre penable", 64'(bus.o_penable), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst psel", 64'(bus.o_psel), 64'd0);
    check_eq("rst penable", 64'(bus.o_penable), 64'd0);
    check_eq("rst rsp_valid", 64'(bus.o_response_valid), 64'd0);
    check_eq("rst cmd_ready", 64'(bus.o_command_ready), 64'd1);
    check_eq("rst paddr", 64'(bus.o_paddr), 64'd0);
    @(negedge clk);
    check_eq("rst no response", 64'(bus.o_response_valid), 64'd0);

    run_xfer("post_rst", 1'b0, 16'h0070, 3'b000, 4'h0, 32'h0, 0, 32'h7777_0001, 1'b0, acc);
    check_eq("post_rst access cycles", 64'(acc), 64'd1);
    finish_rsp("post_rst", 32'h7777_0001, 2'b00, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rggen_apb_requester.md
# rggen_apb_requester

APB initiator bridge: accepts one command at a time on a valid/ready command channel, drives a single APB4 transfer (SETUP then ACCESS), and returns read data and status on a valid/ready response channel. It is the counterpart of the generated register blocks' APB host interface. It drives their `i_paddr`/`i_psel`/`i_penable`/… ports from a local controller, bench master or CPU-side fabric. An optional timeout converts a hung slave into an error response.

## Interface
- ADDRESS_WIDTH, 16, APB address width
- DATA_WIDTH, 32, data width (multiple of 8)
- TIMEOUT_CYCLES, 256, maximum ACCESS cycles before abort; 0 disables the timeout
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high (one clock; synchronous active-high reset is fixed)
- i_command_valid  input  1  command request
- o_command_ready  output  1  command accepted when both valid and ready are high
- i_write  input  1  1 = write, 0 = read
- i_address  input  ADDRESS_WIDTH  byte address
- i_prot  input  3  pprot value
- i_strobe  input  DATA_WIDTH/8  byte strobes (writes only)
- i_write_data  input  DATA_WIDTH  write data
- o_response_valid  output  1  response available
- i_response_ready  input  1  response consumed when both valid and ready are high
- o_read_data  output  DATA_WIDTH  read data (0 for writes and errors)
- o_status  output  2  00 OK, 10 slave error, 11 timeout
- o_paddr, o_pprot, o_psel, o_penable, o_pwrite, o_pwdata, o_pstrb  output  APB widths  APB request
- i_pready, i_prdata, i_pslverr  input  1/DATA_WIDTH/1  APB completion

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESPONSE.
- IDLE:
  - o_command_ready = 1.
  - On handshake, register write, address, prot, strobe and write_data, then go to SETUP.
- SETUP: psel = 1, penable = 0 for exactly one cycle, then ACCESS.
- ACCESS:
  - psel = 1, penable = 1.
  - APB address/control/data are stable from SETUP through the end of ACCESS.
  - i_pready = 1: capture i_prdata (reads only, else 0). Status = i_pslverr ? 10 : 00. Go to RESPONSE.
  - Timeout, when TIMEOUT_CYCLES > 0: a counter cleared on entry to ACCESS increments each ACCESS cycle without pready. When it equals TIMEOUT_CYCLES−1 and pready is still low, the transfer aborts: read_data = 0, status = 11, go to RESPONSE. A pready in the same cycle as the limit wins and completes normally.
- RESPONSE:
  - o_response_valid = 1.
  - Data and status are held stable until i_response_ready, then IDLE.
- Output values by transfer type:
  - Reads: o_pstrb = 0, o_pwdata = 0.
  - Writes: o_pstrb = captured strobe.
- i_pready, i_prdata and i_pslverr are ignored outside ACCESS.
- Back-to-back: a new command is accepted only in IDLE, so a zero-wait transfer occupies ≥4 cycles (IDLE, SETUP, ACCESS, RESPONSE).

## Timing
- Reset values:
  - state = IDLE, o_command_ready = 1.
  - o_psel = o_penable = 0, o_response_valid = 0.
  - All data, address and status outputs = 0.
- All outputs are registered, except o_command_ready, which decodes directly from state.
- Latency:
  - Command handshake at edge N → psel = 1 at N+1, penable = 1 at N+2.
  - pready sampled high at edge M → response_valid = 1 after M, psel/penable = 0 after M.
- Reset mid-transfer: psel/penable deassert after the reset edge. The pending command/response is discarded with no response issued.
- Counter width is $clog2(TIMEOUT_CYCLES+1), with a minimum of 1.

## Structure
- Shared package `rggen_apb_requester_pkg`:
  - state enum type.
  - Status constants: STATUS_OKAY = 2'b00, STATUS_SLAVE_ERROR = 2'b10, STATUS_TIMEOUT = 2'b11.
- Sub-module `rggen_apb_timeout_counter`:
  - parameter LIMIT; inputs clear, enable; output expired.
  - When LIMIT = 0, expired is tied to 0.
- FSM, capture registers and the APB output drive live in the top module.

## Test plan
- Zero-wait write: address 0x0010, data 0xDEADBEEF, strobe 0xF.
  - Expect psel at N+1 and penable at N+2, with paddr = 0x0010, pwrite = 1, pstrb = 0xF.
  - Expect response status 00 and read_data 0.
- Read with 3 wait states returning prdata 0x12345678.
  - Expect ACCESS held for 4 cycles with paddr stable and pstrb = 0.
  - Expect response read_data 0x12345678, status 00.
- Read with pslverr = 1 at pready → status 10, read_data 0.
- TIMEOUT_CYCLES = 8, pready never asserted.
  - Expect penable high for exactly 8 cycles, then psel = 0 and status 11.
  - Repeat with pready arriving on the 8th cycle → status 00.
- Response backpressure: i_response_ready held low for 5 cycles.
  - Expect response_valid and data stable for the whole stall.
  - Expect command_ready = 0 and a second command not accepted until after the response handshake.
- rst asserted during ACCESS.
  - Expect psel/penable = 0 and response_valid = 0 on the next edge, then command_ready = 1.
